// File: rtl/rc4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_pkg : shared RC4 constants and PRGA state encoding
// Revision 1.0
// ----------------------------------------------------------------------------
package rc4_pkg;

  localparam int S_SIZE = 256;
  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INC_I  = 4'd1,
    ST_RD_SI  = 4'd2,
    ST_CALC_J = 4'd3,
    ST_RD_SJ  = 4'd4,
    ST_WR_J   = 4'd5,
    ST_WR_I   = 4'd6,
    ST_RD_F   = 4'd7,
    ST_XOR_WR = 4'd8,
    ST_NEXT   = 4'd9,
    ST_DONE   = 4'd10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_prga_decrypt_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_prga_decrypt_if : control handshake plus S-mem, ROM and RAM buses
// Revision 1.0
// ----------------------------------------------------------------------------
interface rc4_prga_decrypt_if #(
  parameter int ADDR_W = 5
) ();
  import rc4_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_idx;
  byte_t             s_addr;
  byte_t             s_wdata;
  logic              s_wren;
  byte_t             s_rdata;
  logic [ADDR_W-1:0] rom_addr;
  byte_t             rom_rdata;
  logic [ADDR_W-1:0] ram_addr;
  byte_t             ram_wdata;
  logic              ram_wren;

  // The decryptor masters all three memory buses.
  modport master (
    input  start, s_rdata, rom_rdata,
    output busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
           rom_addr, ram_addr, ram_wdata, ram_wren
  );

  modport slave (
    output start, s_rdata, rom_rdata,
    input  busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
           rom_addr, ram_addr, ram_wdata, ram_wren
  );

endinterface
`default_nettype wire

// File: rtl/rc4_char_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_char_check : combinational plaintext byte legality test
// Revision 1.0
// ----------------------------------------------------------------------------
module rc4_char_check #(
  parameter logic [7:0] CHAR_LO     = 8'h61,
  parameter logic [7:0] CHAR_HI     = 8'h7A,
  parameter bit         ALLOW_SPACE = 1'b1
) (
  input  wire logic [7:0] i_char,
  output logic            o_legal
);
  logic w_in_range;
  logic w_space;

  assign w_in_range = (i_char >= CHAR_LO) && (i_char <= CHAR_HI);
  assign w_space    = ALLOW_SPACE && (i_char == 8'h20);
  assign o_legal    = w_in_range || w_space;

endmodule
`default_nettype wire

// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_prga_decrypt : RC4 PRGA walking S-mem, XOR-decrypting ROM into RAM
// Revision 1.0
// ----------------------------------------------------------------------------
module rc4_prga_decrypt #(
  parameter int         MSG_LEN     = 32,
  parameter int         ADDR_W      = 5,
  parameter int         MEM_LAT     = 2,
  parameter bit         CHECK_EN    = 1'b1,
  parameter logic [7:0] CHAR_LO     = 8'h61,
  parameter logic [7:0] CHAR_HI     = 8'h7A,
  parameter bit         ALLOW_SPACE = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  rc4_prga_decrypt_if.master bus
);
  import rc4_pkg::*;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(MSG_LEN - 1);
  localparam logic [2:0]        c_WAIT = 3'(MEM_LAT);

  state_t            r_state;
  state_t            w_next;
  byte_t             r_i, r_j, r_si, r_sj, r_f;
  logic [ADDR_W-1:0] r_k;
  logic [2:0]        r_wait;

  byte_t             r_s_addr, r_s_wdata, r_ram_wdata;
  logic              r_s_wren, r_ram_wren, r_pass;
  logic [ADDR_W-1:0] r_rom_addr, r_ram_addr, r_fail_idx;

  logic              w_busy, w_done, w_rd_state, w_wait_done, w_legal;
  byte_t             w_p;

  assign w_p         = r_f ^ bus.rom_rdata;
  assign w_rd_state  = (r_state == ST_RD_SI) || (r_state == ST_RD_SJ) || (r_state == ST_RD_F);
  assign w_wait_done = (r_wait == 3'd0);

  generate
    if (CHECK_EN) begin : g_check
      rc4_char_check #(
        .CHAR_LO     (CHAR_LO),
        .CHAR_HI     (CHAR_HI),
        .ALLOW_SPACE (ALLOW_SPACE)
      ) u_check (
        .i_char  (w_p),
        .o_legal (w_legal)
      );
    end else begin : g_no_check
      assign w_legal = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_INC_I;
      ST_INC_I:  w_next = ST_RD_SI;
      ST_RD_SI:  if (w_wait_done) w_next = ST_CALC_J;
      ST_CALC_J: w_next = ST_RD_SJ;
      ST_RD_SJ:  if (w_wait_done) w_next = ST_WR_J;
      ST_WR_J:   w_next = ST_WR_I;
      ST_WR_I:   w_next = ST_RD_F;
      ST_RD_F:   if (w_wait_done) w_next = ST_XOR_WR;
      ST_XOR_WR: w_next = w_legal ? ST_NEXT : ST_DONE;
      ST_NEXT:   w_next = (r_k == c_LAST) ? ST_DONE : ST_INC_I;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_DONE: w_done = 1'b1;
      default: w_busy = 1'b1;
    endcase
  end

  // Memory strobes are registered, so each write lands in the cycle after its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i <= '0; r_j <= '0; r_k <= '0; r_si <= '0; r_sj <= '0; r_f <= '0;
      r_wait <= '0;
      r_s_addr <= '0; r_s_wdata <= '0; r_s_wren <= 1'b0;
      r_rom_addr <= '0; r_ram_addr <= '0; r_ram_wdata <= '0; r_ram_wren <= 1'b0;
      r_pass <= 1'b0; r_fail_idx <= '0;
    end else begin
      r_s_wren   <= 1'b0;
      r_ram_wren <= 1'b0;
      // One down-counter serves every read state; reloaded outside them.
      if (!w_rd_state)       r_wait <= c_WAIT;
      else if (!w_wait_done) r_wait <= r_wait - 3'd1;

      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_i <= '0; r_j <= '0; r_k <= '0;
          r_pass <= 1'b0; r_fail_idx <= '0;
        end
        ST_INC_I: begin
          r_i        <= r_i + 8'd1;
          r_rom_addr <= r_k;
          r_ram_addr <= r_k;
        end
        ST_RD_SI: begin
          r_s_addr <= r_i;
          if (w_wait_done) r_si <= bus.s_rdata;
        end
        ST_CALC_J: r_j <= r_j + r_si;
        ST_RD_SJ: begin
          r_s_addr <= r_j;
          if (w_wait_done) r_sj <= bus.s_rdata;
        end
        ST_WR_J: begin
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_s_wren  <= 1'b1;
        end
        ST_WR_I: begin
          r_s_addr  <= r_i;
          r_s_wdata <= r_sj;
          r_s_wren  <= 1'b1;
        end
        ST_RD_F: begin
          r_s_addr <= r_si + r_sj;
          if (w_wait_done) r_f <= bus.s_rdata;
        end
        ST_XOR_WR: begin
          if (!w_legal) begin
            r_fail_idx <= r_k;
            r_pass     <= 1'b0;
          end else begin
            r_ram_wdata <= w_p;
            r_ram_wren  <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_k == c_LAST) r_pass <= 1'b1;
          else               r_k    <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass      = r_pass;
  assign bus.fail_idx  = r_fail_idx;
  assign bus.s_addr    = r_s_addr;
  assign bus.s_wdata   = r_s_wdata;
  assign bus.s_wren    = r_s_wren;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wren  = r_ram_wren;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rc4_prga_decrypt : directed bench over four decryptor builds
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_rc4_prga_decrypt;

  localparam int           NI    = 4;
  localparam logic [23:0]  c_KEY = 24'h000249;
  localparam logic [255:0] c_PT  = "the quick brown fox jumps over a";

  // Build 0: 32-byte KSA vector; 1/2: identity S at MEM_LAT 1/4; 3: abort case.
  function automatic int lat_of(input int g);
    case (g)
      1:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction
  function automatic int msg_of(input int g);
    return (g == 0) ? 32 : 2;
  endfunction
  function automatic int chk_of(input int g);
    return (g == 0 || g == 3) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v     [NI];
  logic       busy_v      [NI];
  logic       done_v      [NI];
  logic       pass_v      [NI];
  logic [4:0] fail_v      [NI];
  logic [7:0] s_addr_v    [NI];
  logic [7:0] s_wdata_v   [NI];
  logic       s_wren_v    [NI];
  logic [4:0] rom_addr_v  [NI];
  logic [4:0] ram_addr_v  [NI];
  logic [7:0] ram_wdata_v [NI];
  logic       ram_wren_v  [NI];

  logic [7:0] smem   [NI][256];
  logic [7:0] load_s [NI][256];
  logic [7:0] rom    [NI][32];
  logic [7:0] ram    [NI][32];
  logic [7:0] s_pipe [NI][3];
  logic [7:0] r_pipe [NI][3];
  logic       mem_load;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    rc4_prga_decrypt_if #(.ADDR_W(5)) bus ();
    rc4_prga_decrypt #(
      .MSG_LEN     (msg_of(g)),
      .ADDR_W      (5),
      .MEM_LAT     (LAT),
      .CHECK_EN    (chk_of(g) != 0),
      .CHAR_LO     (8'h61),
      .CHAR_HI     (8'h7A),
      .ALLOW_SPACE (1'b1)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.start       = start_v[g];
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;
    assign pass_v[g]       = bus.pass;
    assign fail_v[g]       = bus.fail_idx;
    assign s_addr_v[g]     = bus.s_addr;
    assign s_wdata_v[g]    = bus.s_wdata;
    assign s_wren_v[g]     = bus.s_wren;
    assign rom_addr_v[g]   = bus.rom_addr;
    assign ram_addr_v[g]   = bus.ram_addr;
    assign ram_wdata_v[g]  = bus.ram_wdata;
    assign ram_wren_v[g]   = bus.ram_wren;
    if (LAT == 1) begin : g_comb
      assign bus.s_rdata   = smem[g][bus.s_addr];
      assign bus.rom_rdata = rom[g][bus.rom_addr];
    end else begin : g_pipe
      assign bus.s_rdata   = s_pipe[g][LAT-2];
      assign bus.rom_rdata = r_pipe[g][LAT-2];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_load) begin
        for (int n = 0; n < 256; n++) smem[g][n] <= load_s[g][n];
        for (int a = 0; a < 32; a++) ram[g][a] <= 8'hEE;
      end else begin
        if (s_wren_v[g])   smem[g][s_addr_v[g]]  <= s_wdata_v[g];
        if (ram_wren_v[g]) ram[g][ram_addr_v[g]] <= ram_wdata_v[g];
      end
      s_pipe[g][0] <= smem[g][s_addr_v[g]];
      r_pipe[g][0] <= rom[g][rom_addr_v[g]];
      for (int m = 1; m < 3; m++) begin
        s_pipe[g][m] <= s_pipe[g][m-1];
        r_pipe[g][m] <= r_pipe[g][m-1];
      end
    end
  end

  int overlap = 0;
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++)
      if (s_wren_v[g] && ram_wren_v[g]) overlap++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(posedge clk); #1 mem_load = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;
  endtask

  // Returns the number of clock edges from the start-sampling edge to done.
  task automatic run(input int g, input int max_edges, output int lat);
    @(posedge clk); #1 start_v[g] = 1'b1;
    @(posedge clk); #1 start_v[g] = 1'b0;
    lat = 1;
    while (!done_v[g] && lat < max_edges) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_identity_run(input int g, input int exp_lat);
    int lat;
    run(g, 200, lat);
    check($sformatf("id%0d_cycles", g), lat, exp_lat);
    check($sformatf("id%0d_ram0", g), ram[g][0], 8'h61);
    check($sformatf("id%0d_ram1", g), ram[g][1], 8'h63);
    check($sformatf("id%0d_s2", g), smem[g][2], 8'h03);
    check($sformatf("id%0d_s3", g), smem[g][3], 8'h02);
    check($sformatf("id%0d_pass", g), pass_v[g], 1'b1);
    check($sformatf("id%0d_fail_idx", g), fail_v[g], 5'd0);
  endtask

  logic [7:0] ks [256];
  logic [7:0] ps [256];
  logic [7:0] tmp, kb, pb;
  logic [255:0] pt_v;
  int ii, jj, lat, n, d1, d2, nd, mis;
  logic b26, b27;

  initial begin
    rst_n = 1'b0;
    mem_load = 1'b0;
    for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
    pt_v = c_PT;

    // Reference KSA for key 00 02 49, then PRGA to build ciphertext.
    for (int i = 0; i < 256; i++) ks[i] = 8'(i);
    jj = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0: kb = c_KEY[23:16];
        1: kb = c_KEY[15:8];
        default: kb = c_KEY[7:0];
      endcase
      jj = (jj + int'(ks[i]) + int'(kb)) & 255;
      tmp = ks[i]; ks[i] = ks[jj]; ks[jj] = tmp;
    end
    for (int i = 0; i < 256; i++) ps[i] = ks[i];
    ii = 0; jj = 0;
    for (int k = 0; k < 32; k++) begin
      ii = (ii + 1) & 255;
      jj = (jj + int'(ps[ii])) & 255;
      tmp = ps[ii]; ps[ii] = ps[jj]; ps[jj] = tmp;
      kb = ps[(int'(ps[ii]) + int'(ps[jj])) & 255];
      pb = pt_v[255-8*k -: 8];
      rom[0][k] = pb ^ kb;
    end

    for (int i = 0; i < 256; i++) begin
      load_s[0][i] = ks[i];
      for (int g = 1; g < NI; g++) load_s[g][i] = 8'(i);
    end
    for (int g = 1; g < NI; g++)
      for (int a = 0; a < 32; a++) rom[g][a] = 8'h00;
    rom[1][0] = 8'h63; rom[1][1] = 8'h66;
    rom[2][0] = 8'h63; rom[2][1] = 8'h66;
    rom[3][0] = 8'h63; rom[3][1] = 8'h02;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {busy_v[0], done_v[0], pass_v[0], fail_v[0], s_addr_v[0], s_wdata_v[0], s_wren_v[0],
           rom_addr_v[0], ram_addr_v[0], ram_wdata_v[0], ram_wren_v[0]}, 64'd0);
    rst_n = 1'b1;
    load_mem();

    // Identity S, two bytes, MEM_LAT 1 and 4.
    check_identity_run(1, 25);
    check_identity_run(2, 43);

    // Byte 1 decrypts to 07 and aborts the run.
    run(3, 200, lat);
    check("abort_cycles", lat, 30);
    check("abort_pass", pass_v[3], 1'b0);
    check("abort_fail_idx", fail_v[3], 5'd1);
    check("abort_ram0", ram[3][0], 8'h61);
    check("abort_ram1_untouched", ram[3][1], 8'hEE);

    // Reset in the middle of the first swap.
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    n = 0;
    while (!s_wren_v[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_wren_seen", s_wren_v[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_wren", s_wren_v[0], 1'b0);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    rst_n = 1'b1;
    nd = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done_v[0]) nd++;
    end
    check("rst_no_done", nd, 0);

    // Fresh 32-byte run on reloaded memory.
    load_mem();
    run(0, 600, lat);
    check("full_cycles", lat, 481);
    check("full_pass", pass_v[0], 1'b1);
    check("full_fail_idx", fail_v[0], 5'd0);
    for (int k = 0; k < 32; k++)
      check($sformatf("full_ram%0d", k), ram[0][k], pt_v[255-8*k -: 8]);
    mis = 0;
    for (int i = 0; i < 256; i++) if (smem[0][i] !== ps[i]) mis++;
    check("full_s_final", mis, 0);

    // start held high: one run, then a second only after DONE -> IDLE.
    @(posedge clk); #1 start_v[1] = 1'b1;
    nd = 0; d1 = 0; d2 = 0; b26 = 1'b1; b27 = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (e == 26) b26 = busy_v[1];
      if (e == 27) b27 = busy_v[1];
      if (done_v[1]) begin
        nd++;
        if (nd == 1) d1 = e;
        else if (nd == 2) d2 = e;
      end
      if (e == 40) start_v[1] = 1'b0;
    end
    check("hold_first_done", d1, 25);
    check("hold_idle_busy", b26, 1'b0);
    check("hold_restart_busy", b27, 1'b1);
    check("hold_second_done", d2, 51);
    check("hold_done_count", nd, 2);

    check("wren_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
